uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Oversampling UART receiver sitting directly upstream of the LED controller. It converts the asynchronous `rx` pin into a byte plus a one-cycle `data_valid` strobe, which is the contract the LED controller consumes. It rejects start-bit glitches with 3-sample majority voting and flags framing errors. It also flags parity errors when parity is compiled in.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line bit rate.
- `OVERSAMPLE`, 16: samples per bit. Must be ≥ 8 and even.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `data`  out  8  last good byte, LSB received first.
- `data_valid`  out  1  one-cycle strobe; `data` is new this cycle.
- `frame_err`  out  1  one-cycle strobe; the stop bit was sampled low.
- `parity_err`  out  1  one-cycle strobe; parity mismatch (see Configuration).
- `busy`  out  1  high from start-edge detection until return to IDLE.

## Operation
- **Synchronizer:** `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rxs`.
- **Tick generator:**
  - `DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE)`, i.e. rounded.
  - Counter width is `$clog2(DIV)`.
  - Emits a `tick` every DIV cycles.
  - The counter is cleared on the IDLE start-edge detection so that bit phase aligns to the edge.
- **Per-bit sample counter:** `scnt` runs 0..OVERSAMPLE-1 on ticks and wraps to 0 at bit end.
  - Samples are taken at `scnt = OVERSAMPLE/2-1`, `OVERSAMPLE/2`, and `OVERSAMPLE/2+1`.
  - The bit value is the majority (2 of 3) of those samples.
  - The bit value is decided on the tick after the third sample.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BREAK.
  - **IDLE:** on `rxs` 1→0 (previous sample 1, current 0), go to START with `scnt` = 0.
  - **START:** if the majority is 1, it was a false start; return to IDLE with no strobe. Otherwise, at bit end go to DATA with `bcnt` = 0.
  - **DATA:** shift the majority bit into `shreg[7]` and shift right. At bit end, if `bcnt` = 7, go to PARITY (macro defined) or STOP; else increment `bcnt`.
  - **PARITY:** compare the majority bit with `^shreg` (even parity) and latch the mismatch. At bit end, go to STOP.
  - **STOP:** act at the decision point (mid-bit), not at bit end, so that a back-to-back start edge is never missed.
    - Majority 1: `data <= shreg`; pulse `data_valid`; pulse `parity_err` if a mismatch was latched; go to IDLE.
    - Majority 0: pulse `frame_err` only; `data` is unchanged; go to BREAK.
  - **BREAK:** wait until `rxs` = 1, then go to IDLE. This prevents a held-low line from retriggering.
- **Error exclusivity:** `frame_err` and `data_valid` are never high together. `parity_err` is only ever high together with `data_valid`.

## Timing
- **Reset values:** `data` = 0x00; `data_valid`, `frame_err`, `parity_err`, `busy` = 0. FSM in IDLE; counters at 0.
- **Reset mid-frame:** `rst_n` low aborts immediately to the reset state. A partial byte is never emitted.
- **Latency:** `data_valid` rises about 2 sync cycles plus (OVERSAMPLE/2+2) ticks after the stop-bit edge; exact value ±1 tick.
- **Strobe width:** every strobe is exactly one `clk` cycle. `data` holds until the next `data_valid`.
- **`busy`:** asserted the cycle after edge detection; deasserted on entry to IDLE.
- **No backpressure:** the consumer must accept `data_valid` in the cycle it is high.

## Configuration
- Macro `UART_RX_PARITY_EN`:
  - **Defined:** 11-bit frames (start, 8 data, even parity, stop); the PARITY state is active.
  - **Undefined:** 10-bit frames (8N1); the PARITY state is removed and `parity_err` is tied to 0.

## Structure
- **Package `uart_pkg`:**
  - `uart_rx_state_t` enum for the FSM states.
  - `UART_DATA_W` = 8.
  - `uart_div()` constant function.
- **Sub-module `uart_baud_tick`:**
  - Parameterized by DIV.
  - Inputs: `clk`, `rst_n`, `clr`.
  - Output: `tick`.
  - Reused by the future transmitter.

## Test plan
Bench defaults: CLK_FREQ = 50 MHz, BAUD = 115200, OVERSAMPLE = 16, giving DIV = 27.
- **Single byte:** send 8N1 byte 0x35 ('5') → exactly one `data_valid` pulse with `data` = 0x35; no error strobes; `busy` low afterwards.
- **Back-to-back bytes:** send 0x41 then 0x39 with zero idle between stop and start → two `data_valid` pulses with 0x41 then 0x39; none lost.
- **Start-bit glitch:** drive `rx` low for 3 ticks (81 cycles) → no strobes; `busy` pulses then returns low; FSM back in IDLE.
- **Framing error:** send 0xA5 with stop bit forced low, then hold low for 3 bit times → one `frame_err` pulse; no `data_valid`; `data` keeps its prior value; no new frame starts until `rx` returns high.
- **Parity (`UART_RX_PARITY_EN` defined):** send 0x07 with parity bit 0 (should be 1) → `data_valid` with `data` = 0x07 and `parity_err` high in the same cycle. Then send 0x07 with parity bit 1 → `data_valid` only.
- **Reset mid-frame:** pulse `rst_n` low during data bit 4 of 0x5A → all outputs 0 immediately. The next clean frame 0x33 is received as 0x33.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART blocks.
//   uart_rx_state_t : receiver FSM state encoding
//   UART_DATA_W     : payload width of one character
//   uart_div()      : rounded clock divider for one oversample tick
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

    // Cycles per oversample tick, rounded to nearest.
    function automatic int uart_div(input int clk_freq, input int baud, input int os);
        return (clk_freq + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a one-cycle tick every DIV
// clocks. clr restarts the period so the next tick lands DIV cycles later.
// Ports:
//   clk   in  clock
//   rst_n in  asynchronous active-low reset
//   clr   in  restart the divider this cycle (suppresses tick)
//   tick  out one-cycle pulse every DIV cycles
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST) && !clr;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver (8 data bits, LSB first).
// Each bit is decided by a 2-of-3 majority of samples around mid-bit.
// Optional even parity is compiled in with macro UART_RX_PARITY_EN
// (11-bit frames); without it frames are 8N1 and parity_err is 0.
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   rx         in  serial line, idle high, asynchronous
//   data       out last good byte
//   data_valid out one-cycle strobe, data is new
//   frame_err  out one-cycle strobe, stop bit sampled low
//   parity_err out one-cycle strobe with data_valid on parity mismatch
//   busy       out receiver is inside a frame
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] data,
    output logic                   data_valid,
    output logic                   frame_err,
    output logic                   parity_err,
    output logic                   busy
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);

    // Sample points straddle mid-bit; the decision follows one tick later.
    localparam logic [SW-1:0] S_A   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_B   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_C   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_DEC = SW'(OVERSAMPLE / 2 + 2);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    uart_rx_state_t         state_q;
    logic                   rx_meta_q, rxs_q, rxs_prev_q;
    logic [SW-1:0]          scnt_q;
    logic [2:0]             bcnt_q;
    logic [2:0]             smp_q;
    logic [UART_DATA_W-1:0] shreg_q, data_q;
    logic                   dv_q, fe_q, busy_q;
    logic                   tick, start_edge, decide, bit_end, maj;

    assign start_edge = (state_q == ST_IDLE) && rxs_prev_q && !rxs_q;
    assign decide     = tick && (scnt_q == S_DEC);
    assign bit_end    = tick && (scnt_q == S_END);
    assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

    // Divider restarts on the start edge so ticks are phase-aligned to it.
    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_edge),
        .tick  (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_mis_q, pe_q;
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            scnt_q     <= '0;
            bcnt_q     <= '0;
            smp_q      <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            dv_q       <= 1'b0;
            fe_q       <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_mis_q  <= 1'b0;
            pe_q       <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            dv_q       <= 1'b0;
            fe_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q       <= 1'b0;
`endif
            if (state_q != ST_IDLE && tick) begin
                scnt_q <= (scnt_q == S_END) ? '0 : scnt_q + 1'b1;
                if (scnt_q == S_A) smp_q[0] <= rxs_q;
                if (scnt_q == S_B) smp_q[1] <= rxs_q;
                if (scnt_q == S_C) smp_q[2] <= rxs_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_q <= ST_START;
                        scnt_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (decide && maj) begin
                        state_q <= ST_IDLE;   // glitch, not a real start bit
                        busy_q  <= 1'b0;
                    end else if (bit_end) begin
                        state_q <= ST_DATA;
                        bcnt_q  <= '0;
                    end
                end
                ST_DATA: begin
                    if (decide) shreg_q <= {maj, shreg_q[UART_DATA_W-1:1]};
                    if (bit_end) begin
                        if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (decide)  par_mis_q <= maj ^ (^shreg_q);
                    if (bit_end) state_q   <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    // Resolve at mid-bit so a back-to-back start edge is seen.
                    if (decide) begin
                        if (maj) begin
                            data_q  <= shreg_q;
                            dv_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            pe_q    <= par_mis_q;
`endif
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            fe_q    <= 1'b1;
                            state_q <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    // Line held low: wait for idle before re-arming.
                    if (rxs_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed + random frames for uart_rx_os, checked against a
// frame-level model (a frame with a high stop bit yields its byte, a low
// stop bit yields a framing error, a flipped parity bit a parity error).
module tb_uart_rx_os;
    localparam int BITC = 16 * 27;   // clocks per bit at the bench defaults

    logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
    logic [7:0] data;
    logic       data_valid, frame_err, parity_err, busy;

    int total = 0, bad = 0;

    // monitor state
    int         n_valid = 0, n_ferr = 0, n_perr = 0;
    logic [7:0] got_q[$];
    bit         overlap_seen = 0, perr_alone = 0, wide_seen = 0, busy_seen = 0;
    bit         prev_strobe = 0;

    // model state
    int         exp_valid = 0, exp_ferr = 0, exp_perr = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_data = 8'h00;

    uart_rx_os dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) begin
            n_valid++;
            got_q.push_back(data);
        end
        if (frame_err) n_ferr++;
        if (parity_err) n_perr++;
        if (data_valid && frame_err) overlap_seen = 1;
        if (parity_err && !data_valid) perr_alone = 1;
        if ((data_valid || frame_err) && prev_strobe) wide_seen = 1;
        prev_strobe = data_valid || frame_err;
        if (busy) busy_seen = 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BITC) @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame and updates the model with the expected outcome.
    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_bit);
        if (stop_bit) begin
            exp_valid++;
            exp_q.push_back(d);
            exp_data = d;
`ifdef UART_RX_PARITY_EN
            if (par_flip) exp_perr++;
`endif
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic settle_check(input string tag);
        check({tag, "_nvalid"}, n_valid, exp_valid);
        check({tag, "_nferr"}, n_ferr, exp_ferr);
        check({tag, "_nperr"}, n_perr, exp_perr);
        check({tag, "_data"}, data, exp_data);
        check({tag, "_busy"}, busy, 1'b0);
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
        check({tag, "_leftover"}, got_q.size() + exp_q.size(), 0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;

        // reset
        repeat (5) @(negedge clk);
        check("rst_busy_in", busy, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_dv", data_valid, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_pe", parity_err, 1'b0);
        check("rst_busy", busy, 1'b0);

        // single byte
        send_frame(8'h35, 0, 1);
        idle_cycles(BITC);
        settle_check("single");

        // back-to-back, no idle between stop and start
        send_frame(8'h41, 0, 1);
        send_frame(8'h39, 0, 1);
        idle_cycles(BITC);
        settle_check("b2b");

        // start glitch of 3 ticks
        busy_seen = 0;
        rx = 1'b0;
        repeat (81) @(negedge clk);
        idle_cycles(2 * BITC);
        check("glitch_busy_seen", busy_seen, 1'b1);
        settle_check("glitch");

        // framing error, line held low afterwards
        send_frame(8'hA5, 0, 0);
        rx = 1'b0;
        repeat (3 * BITC) @(negedge clk);
        check("ferr_break_busy", busy, 1'b1);
        check("ferr_nvalid_low", n_valid, exp_valid);
        check("ferr_count_low", n_ferr, exp_ferr);
        idle_cycles(BITC);
        settle_check("ferr");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1, 1);
        idle_cycles(BITC);
        settle_check("par_bad");
        send_frame(8'h07, 0, 1);
        idle_cycles(BITC);
        settle_check("par_good");
`endif

        // random bytes with random short idle gaps
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            send_frame(d, 0, 1);
            idle_cycles(int'($urandom_range(0, BITC)));
        end
        idle_cycles(BITC);
        settle_check("rand");

        // reset in the middle of data bit 4 of 0x5A
        d = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_dv", data_valid, 1'b0);
        check("midrst_fe", frame_err, 1'b0);
        check("midrst_pe", parity_err, 1'b0);
        check("midrst_busy", busy, 1'b0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        exp_data = 8'h00;
        idle_cycles(BITC);
        settle_check("midrst_quiet");
        send_frame(8'h33, 0, 1);
        idle_cycles(BITC);
        settle_check("after_rst");

        check("excl_fe_dv", overlap_seen, 1'b0);
        check("pe_without_dv", perr_alone, 1'b0);
        check("strobe_width", wide_seen, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
